// File: rtl/rle_pkg.sv
// Shared widths, channel FSM states and the run-code packing helper for the RLE encoder.
package rle_pkg;
  localparam int PIX_W  = 8;
  localparam int CNT_W  = 8;
  localparam int CODE_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } rle_state_t;

  function automatic logic [CODE_W-1:0] pack_code(input logic [CNT_W-1:0] cnt,
                                                  input logic [PIX_W-1:0] val);
    return {cnt, val};
  endfunction
endpackage

// File: rtl/rle_encoder_if.sv
// Three-channel pixel-in / run-code-out bus; RLE_STATS_EN adds the per-channel code_count field.
interface rle_encoder_if;
  import rle_pkg::*;

  logic [PIX_W-1:0]  R, G, B;
  logic [2:0]        in_valid;
  logic [2:0]        in_last;
  logic [2:0]        in_ready;
  logic [CODE_W-1:0] R_code, G_code, B_code;
  logic [2:0]        code_valid;
  logic [2:0]        code_ready;
  logic [2:0]        done;
`ifdef RLE_STATS_EN
  logic [47:0]       code_count;

  modport master (output R, G, B, in_valid, in_last, code_ready,
                  input  in_ready, R_code, G_code, B_code, code_valid, done, code_count);
  modport slave  (input  R, G, B, in_valid, in_last, code_ready,
                  output in_ready, R_code, G_code, B_code, code_valid, done, code_count);
`else
  modport master (output R, G, B, in_valid, in_last, code_ready,
                  input  in_ready, R_code, G_code, B_code, code_valid, done);
  modport slave  (input  R, G, B, in_valid, in_last, code_ready,
                  output in_ready, R_code, G_code, B_code, code_valid, done);
`endif
endinterface

// File: rtl/rle_chan.sv
// One RLE channel: code registered on the edge that ends a run (1 cycle); a full, unaccepted
// output slot drops pix_rdy and freezes the accumulator. RLE_STATS_EN adds a frame code counter.
module rle_chan
  import rle_pkg::*;
#(
  parameter int MAX_RUN = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PIX_W-1:0]  pix_dat,
  input  logic              pix_vld,
  input  logic              pix_last,
  output logic              pix_rdy,
  output logic [CODE_W-1:0] code_dat,
  output logic              code_vld,
  input  logic              code_rdy,
  output logic              done
`ifdef RLE_STATS_EN
  ,
  output logic [15:0]       code_count
`endif
);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_RUN);

  rle_state_t        state_q, state_d;
  logic [PIX_W-1:0]  cur_q, cur_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              vld_q, vld_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic              slot_free, xfer, acc, extend;

  assign slot_free = !vld_q | code_rdy;
  assign xfer      = vld_q & code_rdy;
  assign pix_rdy   = slot_free && (state_q != FLUSH);
  assign acc       = pix_vld & pix_rdy;
  assign extend    = (pix_dat == cur_q) && (cnt_q < MAX_CNT);

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    vld_d   = vld_q & ~code_rdy;
    last_d  = last_q;
    done_d  = xfer & last_q;
    case (state_q)
      IDLE: begin
        if (acc) begin
          if (pix_last) begin
            code_d = pack_code(CNT_W'(1), pix_dat);
            vld_d  = 1'b1;
            last_d = 1'b1;
          end else begin
            cur_d   = pix_dat;
            cnt_d   = CNT_W'(1);
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (acc) begin
          if (extend && pix_last) begin
            code_d  = pack_code(cnt_q + CNT_W'(1), cur_q);
            vld_d   = 1'b1;
            last_d  = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else if (extend) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            // Run broken or full: emit it and restart on the new pixel.
            code_d = pack_code(cnt_q, cur_q);
            vld_d  = 1'b1;
            last_d = 1'b0;
            cur_d  = pix_dat;
            cnt_d  = CNT_W'(1);
            if (pix_last) state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (slot_free) begin
          code_d  = pack_code(cnt_q, cur_q);
          vld_d   = 1'b1;
          last_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cur_q   <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign code_dat = code_q;
  assign code_vld = vld_q;
  assign done     = done_q;

`ifdef RLE_STATS_EN
  logic [15:0] stat_q;
  logic        clr_pend_q;

  // A finished frame arms the clear; the next frame's first pixel performs it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_q     <= '0;
      clr_pend_q <= 1'b0;
    end else if (acc && (state_q == IDLE) && (clr_pend_q || (xfer && last_q))) begin
      stat_q     <= '0;
      clr_pend_q <= 1'b0;
    end else begin
      if (xfer && (stat_q != 16'hFFFF)) stat_q <= stat_q + 16'd1;
      if (xfer && last_q) clr_pend_q <= 1'b1;
    end
  end

  assign code_count = stat_q;
`endif
endmodule

// File: rtl/rle_encoder.sv
// Three independent RLE channels (R=bit0, G=bit1, B=bit2); latency and backpressure as in rle_chan.
// RLE_STATS_EN exposes the per-channel code counters on the bus.
module rle_encoder #(
  parameter int MAX_RUN = 255
) (
  input logic         clk,
  input logic         rst,
  rle_encoder_if.slave bus
);
  rle_chan #(.MAX_RUN(MAX_RUN)) u_r (
    .clk(clk), .rst(rst),
    .pix_dat(bus.R), .pix_vld(bus.in_valid[0]), .pix_last(bus.in_last[0]), .pix_rdy(bus.in_ready[0]),
    .code_dat(bus.R_code), .code_vld(bus.code_valid[0]), .code_rdy(bus.code_ready[0]),
    .done(bus.done[0])
`ifdef RLE_STATS_EN
    , .code_count(bus.code_count[15:0])
`endif
  );

  rle_chan #(.MAX_RUN(MAX_RUN)) u_g (
    .clk(clk), .rst(rst),
    .pix_dat(bus.G), .pix_vld(bus.in_valid[1]), .pix_last(bus.in_last[1]), .pix_rdy(bus.in_ready[1]),
    .code_dat(bus.G_code), .code_vld(bus.code_valid[1]), .code_rdy(bus.code_ready[1]),
    .done(bus.done[1])
`ifdef RLE_STATS_EN
    , .code_count(bus.code_count[31:16])
`endif
  );

  rle_chan #(.MAX_RUN(MAX_RUN)) u_b (
    .clk(clk), .rst(rst),
    .pix_dat(bus.B), .pix_vld(bus.in_valid[2]), .pix_last(bus.in_last[2]), .pix_rdy(bus.in_ready[2]),
    .code_dat(bus.B_code), .code_vld(bus.code_valid[2]), .code_rdy(bus.code_ready[2]),
    .done(bus.done[2])
`ifdef RLE_STATS_EN
    , .code_count(bus.code_count[47:32])
`endif
  );
endmodule

// File: tb/tb_rle_encoder.sv
// Scoreboard bench for rle_encoder (MAX_RUN=4); code_count checks only when RLE_STATS_EN is defined.
module tb_rle_encoder;
  import rle_pkg::*;

  typedef struct packed {
    logic [15:0] code;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rle_encoder_if bus ();
  rle_encoder #(.MAX_RUN(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q [3][$];
  logic [2:0] exp_done = 3'b000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [15:0] code_of(input int ch);
    case (ch)
      0:       return bus.R_code;
      1:       return bus.G_code;
      default: return bus.B_code;
    endcase
  endfunction

  // Monitor: pops the expected code on every transfer and tracks the done pulse that must follow.
  always @(negedge clk) begin
    exp_t       e;
    logic [2:0] nd;
    nd = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (bus.done[i] || exp_done[i]) check($sformatf("done_ch%0d", i), 32'(bus.done[i]), 32'(exp_done[i]));
      if (rst && bus.code_valid[i] && bus.code_ready[i]) begin
        if (exp_q[i].size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_code_ch%0d actual=%h required=none", i, code_of(i));
        end else begin
          e = exp_q[i].pop_front();
          check($sformatf("code_ch%0d", i), 32'(code_of(i)), 32'(e.code));
          nd[i] = e.last;
        end
      end
    end
    exp_done = nd;
  end

  task automatic expect_code(input int ch, input logic [15:0] code, input logic last);
    exp_t e;
    e.code = code;
    e.last = last;
    exp_q[ch].push_back(e);
  endtask

  // Drives at posedge+1, waits for in_ready sampled at negedge, returns at posedge+1 after the transfer.
  task automatic send(input int ch, input logic [7:0] p, input logic last);
    int n;
    case (ch)
      0:       bus.R = p;
      1:       bus.G = p;
      default: bus.B = p;
    endcase
    bus.in_valid[ch] = 1'b1;
    bus.in_last[ch]  = last;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready[ch] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL send_timeout_ch%0d actual=stalled required=in_ready", ch);
    end
    @(posedge clk);
    #1;
    bus.in_valid[ch] = 1'b0;
    bus.in_last[ch]  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d required=0",
               exp_q[0].size() + exp_q[1].size() + exp_q[2].size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst            = 1'b0;
    bus.R          = '0;
    bus.G          = '0;
    bus.B          = '0;
    bus.in_valid   = '0;
    bus.in_last    = '0;
    bus.code_ready = 3'b111;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_code_valid", 32'(bus.code_valid), 32'h0);
    check("rst_in_ready", 32'(bus.in_ready), 32'h7);
    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_R_code", 32'(bus.R_code), 32'h0);
    check("rst_G_code", 32'(bus.G_code), 32'h0);
    check("rst_B_code", 32'(bus.B_code), 32'h0);
    @(posedge clk);
    #1;

    // Run of 5 broken by a last 7: one FLUSH stall cycle.
    expect_code(0, 16'h0305, 1'b0);
    expect_code(0, 16'h0107, 1'b1);
    send(0, 8'd5, 1'b0);
    send(0, 8'd5, 1'b0);
    send(0, 8'd5, 1'b0);
    send(0, 8'd7, 1'b1);
    @(negedge clk);
    check("s1_first_code_latency", 32'(bus.code_valid[0]), 32'h1);
    check("s1_flush_stall", 32'(bus.in_ready[0]), 32'h0);
    @(negedge clk);
    check("s1_after_flush_ready", 32'(bus.in_ready[0]), 32'h1);
    drain();
`ifdef RLE_STATS_EN
    check("stats_r_after_frame", 32'(bus.code_count[15:0]), 32'd2);
`endif

    // Single zero pixel with last from IDLE.
    expect_code(0, 16'h0100, 1'b1);
    send(0, 8'h00, 1'b1);
    @(negedge clk);
    check("s2_single_latency", 32'(bus.code_valid[0]), 32'h1);
`ifdef RLE_STATS_EN
    check("stats_r_cleared", 32'(bus.code_count[15:0]), 32'd0);
`endif
    drain();

    // Ten equal pixels overflow MAX_RUN=4.
    expect_code(1, 16'h04AA, 1'b0);
    expect_code(1, 16'h04AA, 1'b0);
    expect_code(1, 16'h02AA, 1'b1);
    for (int i = 0; i < 10; i++) send(1, 8'hAA, (i == 9));
    drain();

    // Backpressure on B: first code must hold for 5 cycles with input stalled.
    bus.code_ready[2] = 1'b0;
    expect_code(2, 16'h0101, 1'b0);
    expect_code(2, 16'h0102, 1'b0);
    expect_code(2, 16'h0103, 1'b1);
    fork
      begin
        send(2, 8'd1, 1'b0);
        send(2, 8'd2, 1'b0);
        send(2, 8'd3, 1'b1);
      end
      begin
        n = 0;
        @(negedge clk);
        while (!bus.code_valid[2] && n < 50) begin
          @(negedge clk);
          n++;
        end
        for (int i = 0; i < 5; i++) begin
          check("bp_code_hold", 32'(bus.B_code), 32'h0101);
          check("bp_valid_hold", 32'(bus.code_valid[2]), 32'h1);
          check("bp_in_ready_low", 32'(bus.in_ready[2]), 32'h0);
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.code_ready[2] = 1'b1;
      end
    join
    drain();

    // Reset in the middle of a run discards it.
    for (int i = 0; i < 4; i++) send(1, 8'h33, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 32'(bus.in_ready), 32'h7);
    check("midrst_code_valid", 32'(bus.code_valid[1]), 32'h0);
    @(posedge clk);
    #1;
    expect_code(1, 16'h0109, 1'b1);
    send(1, 8'd9, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
